// File: rtl/partition_writer_if.sv
// Bus bundle for the partition writer: hashed tuple input, flush control and
// the line output toward the consumer.
interface partition_writer_if #(
  parameter int NUM_PARTITIONS  = 16,
  parameter int TUPLES_PER_LINE = 8,
  parameter int HASH_BITS       = 32
);
  localparam int PW = $clog2(NUM_PARTITIONS);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // A source holds valid and its data stable until that edge; ready may
  // depend combinationally on the sink's state but never on valid.
  logic                           in_valid;
  logic [HASH_BITS+63:0]          in_data;
  logic                           in_ready;
  logic                           flush_req;
  logic                           flush_done;
  logic                           out_valid;
  logic                           out_ready;
  logic [TUPLES_PER_LINE*64-1:0]  out_data;
  logic [PW-1:0]                  out_partition;
  logic [3:0]                     out_count;

  modport master (
    output in_valid, in_data, flush_req, out_ready,
    input  in_ready, flush_done, out_valid, out_data, out_partition, out_count
  );

  modport slave (
    input  in_valid, in_data, flush_req, out_ready,
    output in_ready, flush_done, out_valid, out_data, out_partition, out_count
  );
endinterface

// File: rtl/partition_writer.sv
// Scatters hashed tuples into per-partition line buffers, emitting a line when a
// partition fills and draining all partial lines in partition order on flush.
module partition_writer #(
  parameter int NUM_PARTITIONS  = 16,
  parameter int TUPLES_PER_LINE = 8,
  parameter int HASH_BITS       = 32
) (
  input  logic              clk,
  input  logic              resetn,
  partition_writer_if.slave bus,
  output logic [1:0]        dbg_state_o
);
  localparam int PW = $clog2(NUM_PARTITIONS);
  localparam int CW = $clog2(TUPLES_PER_LINE);
  localparam int LW = TUPLES_PER_LINE * 64;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q;
  logic          rdy_en_q;
  logic [PW:0]   scan_q;
  logic [3:0]    fill_q [NUM_PARTITIONS];
  logic [63:0]   buf_q  [NUM_PARTITIONS][TUPLES_PER_LINE];
  logic          out_valid_q;
  logic          flush_done_q;
  logic [LW-1:0] out_data_q;
  logic [PW-1:0] out_part_q;
  logic [3:0]    out_count_q;

  logic          out_free;
  logic          accept;
  logic          line_full;
  logic [PW-1:0] in_part;
  logic [3:0]    in_fill;
  logic [PW-1:0] scan_idx;
  logic          scan_end;
  logic [3:0]    scan_fill;
  logic [LW-1:0] full_line_d;
  logic [LW-1:0] flush_line_d;
  logic          unused_hash;

  assign out_free  = !out_valid_q || bus.out_ready;
  assign in_part   = bus.in_data[64 +: PW];
  assign in_fill   = fill_q[in_part];
  assign line_full = (in_fill == 4'(TUPLES_PER_LINE - 1));
  assign accept    = bus.in_valid && bus.in_ready;
  assign scan_idx  = scan_q[PW-1:0];
  assign scan_end  = scan_q[PW];
  assign scan_fill = fill_q[scan_idx];

  assign unused_hash = ^bus.in_data[HASH_BITS+63 : 64+PW];

  // rdy_en_q keeps in_ready low through reset and until the first clean edge.
  assign bus.in_ready      = rdy_en_q && (state_q == RUN) && out_free;
  assign bus.flush_done    = flush_done_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_partition = out_part_q;
  assign bus.out_count     = out_count_q;
  assign dbg_state_o       = state_q;

  // The completing tuple bypasses storage; flush lines mask slots past the fill
  // so unreset buffer contents never leak out.
  always_comb begin
    full_line_d  = '0;
    flush_line_d = '0;
    for (int k = 0; k < TUPLES_PER_LINE; k++) begin
      full_line_d[64*k +: 64] = (k == TUPLES_PER_LINE - 1) ? bus.in_data[63:0]
                                                           : buf_q[in_part][k];
      if (4'(k) < scan_fill) flush_line_d[64*k +: 64] = buf_q[scan_idx][k];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) buf_q[in_part][in_fill[CW-1:0]] <= bus.in_data[63:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= RUN;
      rdy_en_q     <= 1'b0;
      scan_q       <= '0;
      out_valid_q  <= 1'b0;
      flush_done_q <= 1'b0;
      out_data_q   <= '0;
      out_part_q   <= '0;
      out_count_q  <= '0;
      for (int i = 0; i < NUM_PARTITIONS; i++) fill_q[i] <= '0;
    end else begin
      rdy_en_q     <= 1'b1;
      flush_done_q <= 1'b0;
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (accept) begin
            if (line_full) begin
              fill_q[in_part] <= '0;
              out_valid_q     <= 1'b1;
              out_data_q      <= full_line_d;
              out_part_q      <= in_part;
              out_count_q     <= 4'(TUPLES_PER_LINE);
            end else begin
              fill_q[in_part] <= in_fill + 4'd1;
            end
          end
          if (bus.flush_req) begin
            state_q <= FLUSH;
            scan_q  <= '0;
          end
        end
        FLUSH: begin
          // Past the last partition, wait for the final line to leave.
          if (scan_end) begin
            if (out_free) begin
              state_q      <= DONE;
              flush_done_q <= 1'b1;
            end
          end else if (scan_fill == 4'd0) begin
            scan_q <= scan_q + 1'b1;
          end else if (out_free) begin
            fill_q[scan_idx] <= '0;
            out_valid_q      <= 1'b1;
            out_data_q       <= flush_line_d;
            out_part_q       <= scan_idx;
            out_count_q      <= scan_fill;
            scan_q           <= scan_q + 1'b1;
          end
        end
        DONE:    state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_partition_writer.sv
// Self-checking bench for partition_writer: directed scenarios plus random
// traffic checked against per-partition tuple queues.
module tb_partition_writer;
  localparam int NP = 16;
  localparam int PW = $clog2(NP);

  logic       clk;
  logic       resetn;
  logic [1:0] dbg_state;

  partition_writer_if #(.NUM_PARTITIONS(NP)) bus ();

  partition_writer #(.NUM_PARTITIONS(NP)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus.slave),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model / scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int lines_seen = 0;
  int done_seen = 0;
  int flushes_issued = 0;

  logic [63:0]  part_q [NP][$];
  logic [511:0] exp_q[$];
  logic [3:0]   exp_cnt_q[$];
  logic [PW-1:0] exp_part_q[$];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic emit_line(input int p);
    logic [511:0] line;
    line = '0;
    for (int k = 0; k < part_q[p].size(); k++) line[64*k +: 64] = part_q[p][k];
    exp_q.push_back(line);
    exp_cnt_q.push_back(4'(part_q[p].size()));
    exp_part_q.push_back(PW'(p));
    part_q[p].delete();
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NP; i++) part_q[i].delete();
      exp_q.delete();
      exp_cnt_q.delete();
      exp_part_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        lines_seen++;
        check("line_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          check("line_part", bus.out_partition, exp_part_q.pop_front());
          check("line_count", bus.out_count, exp_cnt_q.pop_front());
          check("line_data", bus.out_data, exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        int p;
        p = int'(bus.in_data[64 +: PW]);
        part_q[p].push_back(bus.in_data[63:0]);
        if (part_q[p].size() == 8) emit_line(p);
      end
      if (bus.flush_req) begin
        for (int i = 0; i < NP; i++) if (part_q[i].size() != 0) emit_line(i);
      end
      if (bus.flush_done) done_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] mk_hash(input int p);
    logic [31:0] h;
    h = $urandom();
    h[PW-1:0] = p[PW-1:0];
    return h;
  endfunction

  task automatic send(input int p, input logic [63:0] t, input bit rnd);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = {mk_hash(p), t};
    while (1) begin
      if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.in_ready || guard >= 200) break;
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.in_ready) check("send_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [63:0] rnd_tuple();
    return {$urandom(), $urandom()};
  endfunction

  task automatic pulse_flush();
    bus.flush_req = 1'b1;
    flushes_issued++;
    @(posedge clk); #1;
    bus.flush_req = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    int guard;
    guard = 0;
    while (!bus.flush_done && guard < 500) begin
      if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.flush_done) check("flush_done_wait", bus.flush_done, 1'b1);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int base_done;
    int k;
    bit saw_valid;

    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush_req = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_flush_done", bus.flush_done, 1'b0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_out_count", bus.out_count, 4'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", bus.in_ready, 1'b1);

    // Eight tuples to partition 3 form one full line the cycle after the last.
    bus.out_ready = 1'b1;
    base = lines_seen;
    for (int i = 0; i < 7; i++) send(3, rnd_tuple(), 1'b0);
    check("p3_no_line_yet", bus.out_valid, 1'b0);
    send(3, rnd_tuple(), 1'b0);
    check("p3_out_valid", bus.out_valid, 1'b1);
    check("p3_out_partition", bus.out_partition, 4'd3);
    check("p3_out_count", bus.out_count, 4'd8);
    @(posedge clk); #1;
    check("p3_one_line", lines_seen - base, 1);

    // Partial lines drained by flush in partition order.
    base = lines_seen;
    base_done = done_seen;
    for (int i = 0; i < 3; i++) send(0, rnd_tuple(), 1'b0);
    for (int i = 0; i < 5; i++) send(9, rnd_tuple(), 1'b0);
    pulse_flush();
    wait_done(1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("flush_two_lines", lines_seen - base, 2);
    check("flush_done_once", done_seen - base_done, 1);

    // Back-pressure holds the pending line and blocks input.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(6, rnd_tuple(), 1'b0);
    for (int c = 0; c < 10; c++) begin
      check("hold_in_ready", bus.in_ready, 1'b0);
      check("hold_valid", bus.out_valid, 1'b1);
      check("hold_part", bus.out_partition, 4'd6);
      check("hold_data", bus.out_data, exp_q[0]);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    check("release_valid", bus.out_valid, 1'b0);

    // Tuple and flush request in the same cycle.
    base = lines_seen;
    check("same_cycle_ready", bus.in_ready, 1'b1);
    bus.in_valid  = 1'b1;
    bus.in_data   = {mk_hash(2), rnd_tuple()};
    pulse_flush();
    bus.in_valid  = 1'b0;
    wait_done(1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("same_cycle_one_line", lines_seen - base, 1);

    // Empty flush: no lines, flush_done NP+1 cycles after the request.
    bus.flush_req = 1'b1;
    flushes_issued++;
    @(posedge clk); #1;
    bus.flush_req = 1'b0;
    k = 0;
    saw_valid = 1'b0;
    while (k < 100) begin
      @(posedge clk); #1;
      k++;
      if (bus.out_valid) saw_valid = 1'b1;
      if (bus.flush_done) break;
    end
    check("empty_flush_latency", k, NP + 1);
    check("empty_flush_no_line", saw_valid, 1'b0);
    @(posedge clk); #1;

    // Reset mid-operation discards partial lines.
    for (int i = 0; i < 5; i++) send(4, rnd_tuple(), 1'b0);
    resetn = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_in_ready", bus.in_ready, 1'b0);
    check("mid_rst_flush_done", bus.flush_done, 1'b0);
    check("mid_rst_partition", bus.out_partition, 4'd0);
    check("mid_rst_count", bus.out_count, 4'd0);
    check("mid_rst_data", bus.out_data, '0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    check("post_rst_ready_low", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    check("post_rst_ready_high", bus.in_ready, 1'b1);
    base = lines_seen;
    for (int i = 0; i < 8; i++) send(4, rnd_tuple(), 1'b0);
    @(posedge clk); #1;
    check("post_rst_one_line", lines_seen - base, 1);

    // Random traffic with random back-pressure and occasional flushes.
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        pulse_flush();
        wait_done(1'b1);
      end else begin
        int p;
        p = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, NP - 1));
        send(p, rnd_tuple(), 1'b1);
      end
    end

    bus.out_ready = 1'b1;
    pulse_flush();
    wait_done(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    check("final_done_count", done_seen, flushes_issued);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
